uart_tx: RTL and testbench

- UART transmitter: serialises one byte per request onto the `tx` line.
- Frame format: start bit, 8 data bits LSB first, 1 stop bit.
- Default rate is 19200 baud from the 100 MHz system clock.
- Sits between the BIP processor's output path and the board `tx` pin. It is the counterpart of the existing UART receiver, so a frame from this block is bit-exact to what the receiver accepts.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_gen.sv | 32 +++
 rtl/uart_tx.sv | 133 +++++++++++++
 tb/tb_uart_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver:
// FSM state encoding, default clock/line rates and the bit-period helper.
package uart_pkg;

    localparam int DEF_CLK_FREQ = 100_000_000;
    localparam int DEF_BAUD     = 19_200;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the wrap cycle.
// pre_tick marks the cycle before the wrap so callers can register outputs that must line up with it.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick,
    output logic pre_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign bit_tick = !clear && (count == LAST);
    assign pre_tick = !clear && (count == PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, one stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
import uart_pkg::*;

module uart_tx #(
    parameter int CLK_FREQ  = DEF_CLK_FREQ,
    parameter int BAUD      = DEF_BAUD,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic [2:0]           state;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 bit_tick;
    logic                 pre_tick;
    logic                 accept;
`ifdef UART_TX_PARITY_EN
    logic                 parity;
`endif

    assign accept = (state == ST_IDLE) && tx_start;

    // Counter is held at zero while idle so START always gets a full bit period.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == ST_IDLE),
        .bit_tick(bit_tick),
        .pre_tick(pre_tick)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= tx_data;
        end else if (state == ST_DATA && bit_tick) begin
            shreg <= shreg >> 1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (accept) begin
            parity <= ^tx_data;
        end
    end
`endif

    // tx is driven from a register one step ahead of the state it belongs to,
    // so each transition also loads the line level of the next bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    if (tx_start) begin
                        state   <= ST_START;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
                            tx    <= parity;
`else
                            state <= ST_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            tx      <= shreg[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_tick) begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (pre_tick) begin
                        tx_done <= 1'b1;
                    end
                    if (bit_tick) begin
                        state   <= ST_IDLE;
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: expected bytes are queued on request and
// compared bit by bit against the decoded tx line. Uses a 16-cycle bit period.
module tb_uart_tx;

    localparam int CLK_FREQ  = 100_000_000;
    localparam int BAUD      = 6_250_000;
    localparam int DATA_BITS = 8;
    localparam int CPB       = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NB        = DATA_BITS + 3;
    localparam int N_FRAMES  = 7;
`else
    localparam int NB        = DATA_BITS + 2;
    localparam int N_FRAMES  = 5;
`endif
    localparam int FL        = NB * CPB;

    logic                 clk;
    logic                 reset;
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx;
    logic                 tx_busy;
    logic                 tx_done;

    int n_checks;
    int n_fail;

    logic [7:0] exp_q[$];
    logic [7:0] mon_byte;
    logic [7:0] rx_byte;
    logic       mon_active;
    logic       mon_valid;
    logic       tx_prev;
    logic       gap_check;
    int         mon_cyc;
    int         cyc;
    int         end_cyc;
    int         busy_run;
    int         done_cnt;
    int         frames_seen;
    int         idle_lows;
    int         done_before;

    uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DATA_BITS(DATA_BITS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= DATA_BITS) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == DATA_BITS + 1) return ^b;
`endif
        return 1'b1;
    endfunction

    // Line decoder and scoreboard consumer, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            mon_active = 1'b0;
            busy_run   = 0;
        end else begin
            if (tx_done) done_cnt++;
            if (tx_busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                check("busy_len", busy_run, FL);
                busy_run = 0;
            end
            if (!mon_active && tx_prev && !tx) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    mon_valid = 1'b0;
                end else begin
                    mon_byte  = exp_q.pop_front();
                    mon_valid = 1'b1;
                end
                if (gap_check) begin
                    check("b2b_gap", cyc - end_cyc - 1, 1);
                    gap_check = 1'b0;
                end
                check("busy_at_start", tx_busy, 1);
                mon_active = 1'b1;
                mon_cyc    = 0;
                rx_byte    = '0;
            end
            if (mon_active) begin
                if (mon_valid && (mon_cyc % CPB == 0 || mon_cyc % CPB == CPB - 1))
                    check($sformatf("bit%0d", mon_cyc / CPB), tx, exp_bit(mon_byte, mon_cyc / CPB));
                if (mon_cyc % CPB == CPB / 2 && mon_cyc / CPB >= 1 && mon_cyc / CPB <= DATA_BITS)
                    rx_byte[mon_cyc / CPB - 1] = tx;
                if (mon_cyc == FL - 1) begin
                    check("done_at_end", tx_done, 1);
                    if (mon_valid) check("loopback", rx_byte, mon_byte);
                    frames_seen++;
                    end_cyc    = cyc;
                    mon_active = 1'b0;
                end else begin
                    mon_cyc++;
                end
            end
        end
        tx_prev = tx;
    end

    task automatic send(input logic [7:0] b, input logic expect_frame);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        if (expect_frame) exp_q.push_back(b);
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!tx_done && n < 2 * FL + 10) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", tx_done, 1);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; end_cyc = 0; busy_run = 0;
        done_cnt = 0; frames_seen = 0; mon_active = 1'b0; mon_valid = 1'b0;
        tx_prev = 1'b1; gap_check = 1'b0; mon_cyc = 0; mon_byte = '0; rx_byte = '0;
        reset = 1'b0; tx_start = 1'b0; tx_data = '0;

        #100 reset = 1'b1;
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        idle_lows = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!tx || tx_busy || tx_done) idle_lows++;
        end
        check("idle_quiet", idle_lows, 0);

        send(8'h01, 1'b1);
        wait_done();
        @(negedge clk);
        check("idle_after_01", tx_busy, 0);

        send(8'hA5, 1'b1);
        repeat (60) @(negedge clk);
        send(8'h3C, 1'b0);
        wait_done();
        repeat (2 * FL) @(negedge clk);
        check("no_second_frame", frames_seen, 2);

        send(8'hFF, 1'b1);
        wait_done();
        @(negedge clk);
        check("b2b_idle_busy", tx_busy, 0);
        check("b2b_idle_tx", tx, 1);
        tx_data   = 8'h55;
        tx_start  = 1'b1;
        gap_check = 1'b1;
        exp_q.push_back(8'h55);
        @(negedge clk);
        tx_start = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);

        send(8'h00, 1'b1);
        repeat (70) @(negedge clk);
        done_before = done_cnt;
        #2 reset = 1'b0;
        #1;
        check("abort_tx", tx, 1);
        check("abort_busy", tx_busy, 0);
        check("abort_done", tx_done, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2 * FL) @(negedge clk);
        check("abort_no_done", done_cnt, done_before);

        send(8'h81, 1'b1);
        wait_done();
        repeat (4) @(negedge clk);

`ifdef UART_TX_PARITY_EN
        send(8'h07, 1'b1);
        wait_done();
        repeat (4) @(negedge clk);
        send(8'h03, 1'b1);
        wait_done();
        repeat (4) @(negedge clk);
`endif

        check("queue_empty", exp_q.size(), 0);
        check("done_count", done_cnt, N_FRAMES);
        check("frames_seen", frames_seen, N_FRAMES);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
